// File: rtl/ddr_cmd_sequencer.sv
// Command-phase sequencer ahead of the DDR command generator: accepts single-burst
// read/write requests, schedules periodic auto-refresh and times each command phase.
module ddr_cmd_sequencer #(
  parameter int T_RCD            = 2,
  parameter int CAS_LAT          = 2,
  parameter int BURST_CYCLES     = 4,
  parameter int T_WR             = 2,
  parameter int T_RP             = 2,
  parameter int T_RFC            = 10,
  parameter int REFRESH_INTERVAL = 1040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [24:0] req_addr,
  output logic        req_ready,
  output logic [3:0]  cmd_state,
  output logic [24:0] ctrl_addr,
  output logic        rd_capture,
  output logic        wr_data_en,
  output logic        done,
  output logic        done_we
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int WR_WAIT  = T_WR + T_RP;
  localparam int MAX_WAIT = max2(max2(max2(T_RCD - 1, CAS_LAT), max2(BURST_CYCLES, WR_WAIT)),
                                 max2(T_RFC - 1, 2));
  localparam int CNT_W    = $clog2(MAX_WAIT);
  localparam int RT_W     = $clog2(REFRESH_INTERVAL);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ACTIVE    = 4'd1,
    S_WAIT_RCD  = 4'd2,
    S_READ      = 4'd3,
    S_WAIT_CAS  = 4'd4,
    S_RD_BURST  = 4'd5,
    S_WRITE     = 4'd6,
    S_WR_BURST  = 4'd7,
    S_WR_RECOV  = 4'd8,
    S_AUTOREF   = 4'd9,
    S_WAIT_RFC  = 4'd10,
    S_DONE      = 4'd11,
    S_REF_DONE  = 4'd12
  } state_e;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RT_W-1:0]    ref_timer;
  logic               ref_pending;
  logic               we_flag;
  logic               accept;
  logic               ref_start;
  logic               cnt_zero;

  assign req_ready = (state == S_IDLE) && init_done && !ref_pending;
  assign accept    = req_valid && req_ready;
  assign ref_start = (state == S_IDLE) && init_done && ref_pending;
  assign cnt_zero  = (cnt == '0);

  // State, shared down-counter and the request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_flag   <= 1'b0;
      ctrl_addr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_flag   <= req_we;
        ctrl_addr <= req_addr;
      end
    end
  end

  // Each wait state is entered with the counter at (duration - 1) and leaves at zero
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (ref_start)   state_nxt = S_AUTOREF;
        else if (accept) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        state_nxt = S_WAIT_RCD;
        cnt_nxt   = CNT_W'(T_RCD - 2);
      end
      S_WAIT_RCD: begin
        if (cnt_zero) state_nxt = we_flag ? S_WRITE : S_READ;
        else          cnt_nxt   = cnt - CNT_W'(1);
      end
      S_READ: begin
        state_nxt = S_WAIT_CAS;
        cnt_nxt   = CNT_W'(CAS_LAT - 1);
      end
      S_WAIT_CAS: begin
        if (cnt_zero) begin
          state_nxt = S_RD_BURST;
          cnt_nxt   = CNT_W'(BURST_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_RD_BURST: begin
        if (cnt_zero) state_nxt = S_DONE;
        else          cnt_nxt   = cnt - CNT_W'(1);
      end
      S_WRITE: begin
        state_nxt = S_WR_BURST;
        cnt_nxt   = CNT_W'(BURST_CYCLES - 1);
      end
      S_WR_BURST: begin
        if (cnt_zero) begin
          state_nxt = S_WR_RECOV;
          cnt_nxt   = CNT_W'(WR_WAIT - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_WR_RECOV: begin
        if (cnt_zero) state_nxt = S_DONE;
        else          cnt_nxt   = cnt - CNT_W'(1);
      end
      S_AUTOREF: begin
        state_nxt = S_WAIT_RFC;
        cnt_nxt   = CNT_W'(T_RFC - 2);
      end
      S_WAIT_RFC: begin
        if (cnt_zero) state_nxt = S_REF_DONE;
        else          cnt_nxt   = cnt - CNT_W'(1);
      end
      S_DONE:     state_nxt = S_IDLE;
      S_REF_DONE: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Refresh timer: an expiry wins over the clear so a new request is never lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_timer   <= '0;
      ref_pending <= 1'b0;
    end else if (!init_done) begin
      ref_timer   <= '0;
      ref_pending <= 1'b0;
    end else if (ref_timer == RT_W'(REFRESH_INTERVAL - 1)) begin
      ref_timer   <= '0;
      ref_pending <= 1'b1;
    end else begin
      ref_timer <= ref_timer + RT_W'(1);
      if (ref_start) ref_pending <= 1'b0;
    end
  end

  assign cmd_state  = state;
  assign rd_capture = (state == S_RD_BURST);
  assign wr_data_en = (state == S_WR_BURST);
  assign done       = (state == S_DONE);
  assign done_we    = (state == S_DONE) && we_flag;

endmodule
